// File: rtl/low_band_fir.sv
// Low-band FIR MAC engine: pairs each streamed sample with a ROM coefficient,
// accumulates at full precision and emits one shifted, saturated sample per burst.
module low_band_fir #(
    parameter int TAPS   = 1021,
    parameter int SMPL_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 42,
    parameter int SHIFT  = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     seq_in,
    input  logic signed [SMPL_W-1:0] smpl_in,
    input  logic signed [COEF_W-1:0] coeff_in,
    output logic [9:0]               coeff_addr,
    output logic signed [SMPL_W-1:0] flt_out,
    output logic                     flt_vld,
    output logic                     busy,
    output logic                     err
);

    localparam int CNT_W  = $clog2(TAPS + 1);
    localparam int PROD_W = SMPL_W + COEF_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (SMPL_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (SMPL_W - 1)));

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, OUT} state_t;

    state_t                    state, next_state;
    logic [CNT_W-1:0]          tap_cnt;
    logic                      flush_cnt;
    logic                      v1, v2;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [SMPL_W-1:0]  sat_val;
    logic                      tap_full, accept, start, err_set, result_now;

    assign tap_full   = (tap_cnt >= CNT_W'(TAPS));
    assign start      = (state == IDLE) && seq_in;
    assign accept     = start || ((state == ACCUM) && seq_in && !tap_full);
    assign result_now = (state == FLUSH) && (next_state == OUT);
    assign coeff_addr = 10'(tap_full ? CNT_W'(TAPS - 1) : tap_cnt);

    assign err_set = (seq_in && (((state == ACCUM) && tap_full) || (state == FLUSH) || (state == OUT)))
                   || ((state == ACCUM) && !seq_in && (tap_cnt != CNT_W'(TAPS)));

    // The ACCUM cycle that sees seq_in low is the first drain cycle, so two FLUSH
    // cycles complete the three-cycle drain and the last product lands before OUT.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (seq_in) next_state = ACCUM;
            ACCUM:   if (!seq_in) next_state = FLUSH;
            FLUSH:   if (flush_cnt) next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        shifted = acc >>> SHIFT;
        sat_val = shifted[SMPL_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_val = {1'b0, {(SMPL_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            sat_val = {1'b1, {(SMPL_W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            flush_cnt <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            flush_cnt <= (state == FLUSH);
            busy      <= (next_state != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt <= '0;
        end else if (state == IDLE) begin
            tap_cnt <= start ? CNT_W'(1) : '0;
        end else if (state == OUT) begin
            tap_cnt <= '0;
        end else if (accept) begin
            tap_cnt <= tap_cnt + CNT_W'(1);
        end
    end

    // Valid tokens travel alongside the data so bubbles never reach the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            prod <= '0;
            acc  <= '0;
        end else begin
            v1 <= accept;
            v2 <= v1;
            if (v1) begin
                prod <= PROD_W'(smpl_in) * PROD_W'(coeff_in);
            end
            if (start) begin
                acc <= '0;
            end else if (v2) begin
                acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_out <= '0;
            flt_vld <= 1'b0;
            err     <= 1'b0;
        end else begin
            flt_vld <= result_now;
            if (result_now) begin
                flt_out <= sat_val;
            end
            if (start) begin
                err <= 1'b0;
            end else if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule
